// File: rtl/proc_test_mem_responder.sv
// Word-addressed test memory answering processor imem/dmem val/rdy request streams.
// Optional out-of-range detection is enabled by defining PROC_TEST_MEM_RESPONDER_BOUNDS_EN.
module proc_test_mem_responder #(
  parameter int p_num_words = 256,
  parameter int p_latency   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqstream_val,
  output logic        reqstream_rdy,
  input  logic [76:0] reqstream_msg,
  output logic        respstream_val,
  input  logic        respstream_rdy,
  output logic [46:0] respstream_msg
);

  localparam int         AW  = $clog2(p_num_words);
  localparam logic [3:0] LAT = 4'(p_latency);

  localparam logic [2:0] TYPE_READ  = 3'd0;
  localparam logic [2:0] TYPE_WRITE = 3'd1;
  localparam logic [2:0] TYPE_INIT  = 3'd2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t     state, state_n;
  logic [3:0] lat_cnt, lat_cnt_n;

  logic [2:0]  req_type;
  logic [7:0]  req_opaque;
  logic [31:0] req_addr;
  logic [1:0]  req_len;
  logic [31:0] req_data;

  logic [AW-1:0] word_idx;
  logic [1:0]    byte_off;
  logic          in_range;
  logic          req_fire;
  logic          rdy_int;
  logic          is_read;
  logic          is_write;
  logic          mem_we;
  logic [3:0]    wr_lanes;
  logic [31:0]   wr_data;
  logic [31:0]   rd_word;
  logic [31:0]   resp_data;
  logic [1:0]    resp_test;
  logic [46:0]   resp_msg_p1;

  logic [31:0] mem [p_num_words];

  // len 0 means a full word; other values are a byte count
  function automatic logic [3:0] len_mask(input logic [1:0] len);
    case (len)
      2'd1:    return 4'b0001;
      2'd2:    return 4'b0011;
      2'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  // Lanes shifted past byte 3 fall off, so nothing spills into the next word
  function automatic logic [3:0] lane_enables(input logic [1:0] len, input logic [1:0] off);
    logic [6:0] wide;
    wide = {3'b000, len_mask(len)} << off;
    return wide[3:0];
  endfunction

  function automatic logic [31:0] expand_lanes(input logic [3:0] lanes);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{lanes[i]}};
    end
    return m;
  endfunction

  function automatic logic [31:0] read_align(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] len);
    return (word >> {off, 3'b000}) & expand_lanes(len_mask(len));
  endfunction

  assign {req_type, req_opaque, req_addr, req_len, req_data} = reqstream_msg;

  assign word_idx = req_addr[2 +: AW];
  assign byte_off = req_addr[1:0];

`ifdef PROC_TEST_MEM_RESPONDER_BOUNDS_EN
  assign in_range = ~|req_addr[31:2+AW];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:2+AW];
  assign in_range       = 1'b1;
`endif

  // A zero-latency responder can take the next request in the cycle its response fires
  assign rdy_int = (state == IDLE) ||
                   ((state == RESP) && (p_latency == 0) && respstream_rdy);
  assign reqstream_rdy = reset && rdy_int;
  assign req_fire      = reqstream_val && reqstream_rdy;

  assign is_read  = (req_type == TYPE_READ);
  assign is_write = (req_type == TYPE_WRITE) || (req_type == TYPE_INIT);
  assign mem_we   = req_fire && is_write && in_range;
  assign wr_lanes = lane_enables(req_len, byte_off);
  assign wr_data  = req_data << {byte_off, 3'b000};
  assign rd_word  = mem[word_idx];

  always_comb begin
    resp_test = 2'b00;
    resp_data = 32'h0;
    if (!in_range) begin
      resp_test = 2'b01;
      resp_data = 32'hDEAD_BEEF;
    end else if (is_read) begin
      resp_data = read_align(rd_word, byte_off, req_len);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_lanes[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // ---- accept stage -> response register (p1)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_msg_p1 <= '0;
    end else if (req_fire) begin
      resp_msg_p1 <= {req_type, req_opaque, resp_test, req_len, resp_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      lat_cnt <= 4'd0;
    end else begin
      state   <= state_n;
      lat_cnt <= lat_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    lat_cnt_n = lat_cnt;
    case (state)
      IDLE: begin
        if (req_fire) begin
          if (p_latency > 0) begin
            state_n   = WAIT;
            lat_cnt_n = LAT;
          end else begin
            state_n = RESP;
          end
        end
      end
      WAIT: begin
        lat_cnt_n = lat_cnt - 4'd1;
        if (lat_cnt <= 4'd1) state_n = RESP;
      end
      RESP: begin
        if (respstream_rdy) state_n = req_fire ? RESP : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign respstream_val = (state == RESP);
  assign respstream_msg = resp_msg_p1;

endmodule

// File: tb/tb_proc_test_mem_responder.sv
// Bench for proc_test_mem_responder: zero-latency vector table with scoreboard,
// plus latency-3 timing, backpressure and reset sequences.
module tb_proc_test_mem_responder;

  localparam logic [2:0] RD = 3'd0;
  localparam logic [2:0] WR = 3'd1;
  localparam logic [2:0] IN = 3'd2;

`ifdef PROC_TEST_MEM_RESPONDER_BOUNDS_EN
  localparam logic [1:0]  OOB_TEST   = 2'b01;
  localparam logic [31:0] OOB_RD     = 32'hDEAD_BEEF;
  localparam logic [31:0] OOB_WR     = 32'hDEAD_BEEF;
  localparam logic [31:0] WORD0_LAST = 32'h0BAD_F00D;
`else
  localparam logic [1:0]  OOB_TEST   = 2'b00;
  localparam logic [31:0] OOB_RD     = 32'h0BAD_F00D;
  localparam logic [31:0] OOB_WR     = 32'h0000_0000;
  localparam logic [31:0] WORD0_LAST = 32'hFFFF_FFFF;
`endif

  logic clk = 1'b0;
  logic reset;

  logic        req_val_0, req_rdy_0, resp_val_0, resp_rdy_0;
  logic [76:0] req_msg_0;
  logic [46:0] resp_msg_0;
  logic        req_val_3, req_rdy_3, resp_val_3, resp_rdy_3;
  logic [76:0] req_msg_3;
  logic [46:0] resp_msg_3;

  int n_checks = 0;
  int n_pass   = 0;
  logic [46:0] exp_q[$];

  typedef struct {
    logic [2:0]  typ;
    logic [7:0]  opq;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
    logic [1:0]  etest;
    logic [31:0] edata;
  } vec_t;

  vec_t vecs [24];

  always #5 clk = ~clk;

  proc_test_mem_responder #(.p_num_words(256), .p_latency(0)) dut0 (
    .clk(clk), .reset(reset),
    .reqstream_val(req_val_0), .reqstream_rdy(req_rdy_0), .reqstream_msg(req_msg_0),
    .respstream_val(resp_val_0), .respstream_rdy(resp_rdy_0), .respstream_msg(resp_msg_0)
  );

  proc_test_mem_responder #(.p_num_words(256), .p_latency(3)) dut3 (
    .clk(clk), .reset(reset),
    .reqstream_val(req_val_3), .reqstream_rdy(req_rdy_3), .reqstream_msg(req_msg_3),
    .respstream_val(resp_val_3), .respstream_rdy(resp_rdy_3), .respstream_msg(resp_msg_3)
  );

  function automatic logic [76:0] mk_req(input logic [2:0] t, input logic [7:0] o,
                                         input logic [31:0] a, input logic [1:0] l,
                                         input logic [31:0] d);
    return {t, o, a, l, d};
  endfunction

  function automatic logic [46:0] mk_resp(input logic [2:0] t, input logic [7:0] o,
                                          input logic [1:0] ts, input logic [1:0] l,
                                          input logic [31:0] d);
    return {t, o, ts, l, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Call at a falling edge; returns at the next falling edge after the request is taken
  task automatic send0(input logic [76:0] msg, input logic [46:0] exp, input string name,
                       output int waited);
    waited    = 0;
    req_msg_0 = msg;
    req_val_0 = 1'b1;
    #1;
    while (!req_rdy_0 && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check({name, " accept"}, 64'(req_rdy_0), 64'd1);
    if (req_rdy_0) exp_q.push_back(exp);
    @(negedge clk);
  endtask

  task automatic drain0();
    int g = 0;
    while (exp_q.size() != 0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("scoreboard drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Response monitor for the zero-latency instance
  always begin
    @(negedge clk);
    #2;
    if (resp_val_0 && resp_rdy_0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected response: got %h, expected none", resp_msg_0);
      end else begin
        check("lat0 resp", 64'(resp_msg_0), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    logic [46:0] e;

    vecs[0]  = '{WR,   8'h01, 32'h0000_0200, 2'd0, 32'h1234_5678, 2'b00, 32'h0};
    vecs[1]  = '{RD,   8'h02, 32'h0000_0200, 2'd0, 32'h0,         2'b00, 32'h1234_5678};
    vecs[2]  = '{WR,   8'h03, 32'h0000_0201, 2'd1, 32'h0000_00A5, 2'b00, 32'h0};
    vecs[3]  = '{RD,   8'h04, 32'h0000_0200, 2'd0, 32'h0,         2'b00, 32'h1234_A578};
    vecs[4]  = '{RD,   8'h05, 32'h0000_0202, 2'd2, 32'h0,         2'b00, 32'h0000_1234};
    vecs[5]  = '{RD,   8'h06, 32'h0000_0201, 2'd1, 32'h0,         2'b00, 32'h0000_00A5};
    vecs[6]  = '{RD,   8'h07, 32'h0000_0203, 2'd2, 32'h0,         2'b00, 32'h0000_0012};
    vecs[7]  = '{RD,   8'h08, 32'h0000_0201, 2'd3, 32'h0,         2'b00, 32'h0012_34A5};
    vecs[8]  = '{IN,   8'h09, 32'h0000_0100, 2'd0, 32'h0,         2'b00, 32'h0};
    vecs[9]  = '{IN,   8'h0A, 32'h0000_0104, 2'd0, 32'h1122_3344, 2'b00, 32'h0};
    vecs[10] = '{WR,   8'h0B, 32'h0000_0102, 2'd0, 32'hCAFE_BEEF, 2'b00, 32'h0};
    vecs[11] = '{RD,   8'h0C, 32'h0000_0100, 2'd0, 32'h0,         2'b00, 32'hBEEF_0000};
    vecs[12] = '{RD,   8'h0D, 32'h0000_0104, 2'd0, 32'h0,         2'b00, 32'h1122_3344};
    vecs[13] = '{3'd3, 8'h0E, 32'h0000_0200, 2'd0, 32'hFFFF_FFFF, 2'b00, 32'h0};
    vecs[14] = '{3'd7, 8'h0F, 32'h0000_0200, 2'd1, 32'h0000_00FF, 2'b00, 32'h0};
    vecs[15] = '{RD,   8'h10, 32'h0000_0200, 2'd0, 32'h0,         2'b00, 32'h1234_A578};
    vecs[16] = '{IN,   8'h11, 32'h0000_0000, 2'd0, 32'h0BAD_F00D, 2'b00, 32'h0};
    vecs[17] = '{RD,   8'h12, 32'h0000_0400, 2'd0, 32'h0,         OOB_TEST, OOB_RD};
    vecs[18] = '{RD,   8'h13, 32'hFFFF_FC00, 2'd0, 32'h0,         OOB_TEST, OOB_RD};
    vecs[19] = '{WR,   8'h14, 32'h0000_0400, 2'd0, 32'hFFFF_FFFF, OOB_TEST, OOB_WR};
    vecs[20] = '{RD,   8'h15, 32'h0000_0000, 2'd0, 32'h0,         2'b00, WORD0_LAST};
    vecs[21] = '{WR,   8'h16, 32'h0000_0103, 2'd2, 32'h0000_7766, 2'b00, 32'h0};
    vecs[22] = '{RD,   8'h17, 32'h0000_0100, 2'd0, 32'h0,         2'b00, 32'h66EF_0000};
    vecs[23] = '{RD,   8'h18, 32'h0000_0104, 2'd0, 32'h0,         2'b00, 32'h1122_3344};

    // Reset state, with requests pending to show ready is held low
    reset      = 1'b0;
    req_val_0  = 1'b1;
    req_msg_0  = '0;
    resp_rdy_0 = 1'b1;
    req_val_3  = 1'b1;
    req_msg_3  = '0;
    resp_rdy_3 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset rdy0",  64'(req_rdy_0),  64'd0);
    check("reset val0",  64'(resp_val_0), 64'd0);
    check("reset msg0",  64'(resp_msg_0), 64'd0);
    check("reset rdy3",  64'(req_rdy_3),  64'd0);
    check("reset val3",  64'(resp_val_3), 64'd0);
    @(negedge clk);
    req_val_0 = 1'b0;
    req_val_3 = 1'b0;
    reset     = 1'b1;
    #1;
    check("post-reset rdy0", 64'(req_rdy_0), 64'd1);
    check("post-reset rdy3", 64'(req_rdy_3), 64'd1);

    // Zero-latency vector table, back to back
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      send0(mk_req(vecs[i].typ, vecs[i].opq, vecs[i].addr, vecs[i].len, vecs[i].data),
            mk_resp(vecs[i].typ, vecs[i].opq, vecs[i].etest, vecs[i].len, vecs[i].edata),
            $sformatf("vec%0d", i), w);
      check($sformatf("vec%0d accept wait", i), 64'(w), 64'd0);
    end
    req_val_0 = 1'b0;
    drain0();
    @(negedge clk);

    // Response backpressure: held response, second request not taken
    resp_rdy_0 = 1'b0;
    e = mk_resp(RD, 8'h20, 2'b00, 2'd0, 32'h1234_A578);
    send0(mk_req(RD, 8'h20, 32'h200, 2'd0, 32'h0), e, "bp first", w);
    req_msg_0 = mk_req(RD, 8'h21, 32'h104, 2'd0, 32'h0);
    req_val_0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp val c%0d", k), 64'(resp_val_0), 64'd1);
      check($sformatf("bp msg c%0d", k), 64'(resp_msg_0), 64'(e));
      check($sformatf("bp rdy c%0d", k), 64'(req_rdy_0),  64'd0);
      @(negedge clk);
    end
    resp_rdy_0 = 1'b1;
    send0(mk_req(RD, 8'h21, 32'h104, 2'd0, 32'h0),
          mk_resp(RD, 8'h21, 2'b00, 2'd0, 32'h1122_3344), "bp second", w);
    check("bp second same-cycle accept", 64'(w), 64'd0);
    req_val_0 = 1'b0;
    drain0();

    // Latency 3: accept at cycle t, response valid at t+4
    @(negedge clk);
    req_msg_3 = mk_req(WR, 8'h30, 32'h10, 2'd0, 32'hABCD_0123);
    req_val_3 = 1'b1;
    #1;
    check("lat3 idle rdy", 64'(req_rdy_3), 64'd1);
    @(negedge clk);
    req_msg_3 = mk_req(RD, 8'h31, 32'h10, 2'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("lat3 wait val c%0d", k), 64'(resp_val_3), 64'd0);
      check($sformatf("lat3 wait rdy c%0d", k), 64'(req_rdy_3),  64'd0);
      @(negedge clk);
    end
    #1;
    check("lat3 resp val", 64'(resp_val_3), 64'd1);
    check("lat3 resp rdy", 64'(req_rdy_3),  64'd0);
    check("lat3 resp msg", 64'(resp_msg_3), 64'(mk_resp(WR, 8'h30, 2'b00, 2'd0, 32'h0)));
    @(negedge clk);
    #1;
    check("lat3 back to idle val", 64'(resp_val_3), 64'd0);
    check("lat3 back to idle rdy", 64'(req_rdy_3),  64'd1);
    @(negedge clk);
    req_val_3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("lat3 rd wait c%0d", k), 64'(resp_val_3), 64'd0);
      @(negedge clk);
    end
    #1;
    check("lat3 rd val", 64'(resp_val_3), 64'd1);
    check("lat3 rd msg", 64'(resp_msg_3), 64'(mk_resp(RD, 8'h31, 2'b00, 2'd0, 32'hABCD_0123)));
    @(negedge clk);
    #1;
    check("lat3 rd done", 64'(resp_val_3), 64'd0);

    // Reset during WAIT drops the transaction
    @(negedge clk);
    req_msg_3 = mk_req(WR, 8'h40, 32'h20, 2'd0, 32'h5A5A_5A5A);
    req_val_3 = 1'b1;
    #1;
    check("rstw accept rdy", 64'(req_rdy_3), 64'd1);
    @(negedge clk);
    req_val_3 = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("rstw val", 64'(resp_val_3), 64'd0);
    check("rstw rdy", 64'(req_rdy_3),  64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstw release rdy", 64'(req_rdy_3), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("rstw no stale c%0d", k), 64'(resp_val_3), 64'd0);
    end

    // Reset while a response is held in RESP
    @(negedge clk);
    resp_rdy_3 = 1'b0;
    req_msg_3  = mk_req(RD, 8'h50, 32'h10, 2'd0, 32'h0);
    req_val_3  = 1'b1;
    #1;
    check("rstr accept rdy", 64'(req_rdy_3), 64'd1);
    @(negedge clk);
    req_val_3 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rstr held val", 64'(resp_val_3), 64'd1);
    check("rstr held msg", 64'(resp_msg_3), 64'(mk_resp(RD, 8'h50, 2'b00, 2'd0, 32'hABCD_0123)));
    #2;
    reset = 1'b0;
    #1;
    check("rstr val", 64'(resp_val_3), 64'd0);
    check("rstr msg", 64'(resp_msg_3), 64'd0);
    check("rstr rdy", 64'(req_rdy_3),  64'd0);
    @(negedge clk);
    reset      = 1'b1;
    resp_rdy_3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("rstr no stale c%0d", k), 64'(resp_val_3), 64'd0);
    end
    check("rstr idle rdy", 64'(req_rdy_3), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
